// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises single-word instruction reads and data reads/writes onto one MCB port,
// one transaction outstanding, routing read data back to the issuing client.
module mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_en,
  input  logic [29:0] i_cmd_byte_addr,
  output logic        i_cmd_full,
  input  logic        i_rd_en,
  output logic [31:0] i_rd_data,
  output logic        i_rd_empty,
  input  logic        d_cmd_en,
  input  logic [2:0]  d_cmd_instr,
  input  logic [29:0] d_cmd_byte_addr,
  output logic        d_cmd_full,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_data,
  input  logic [3:0]  d_wr_mask,
  output logic        d_wr_full,
  input  logic        d_rd_en,
  output logic [31:0] d_rd_data,
  output logic        d_rd_empty,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  input  logic        mem_cmd_full,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_mask,
  input  logic        mem_wr_full,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_empty
);
  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;
  state_t state;
  logic pend_i, pend_d, d_wr, owner_d, deliver;
  logic [29:0] addr_i, addr_d;
  logic [31:0] wb_data;
  logic [3:0] wb_mask;
  logic el_i, el_d, pick_d;
  assign el_i = pend_i && i_rd_empty;
  assign el_d = pend_d && (d_wr ? d_wr_full : d_rd_empty);
  assign pick_d = el_d && (!el_i || DATA_FIRST);
  assign mem_cmd_bl = 6'b000000;
  // cmd_full lags pend by one cycle on release so it falls the cycle after mem_cmd_en.
  // The popped MCB word is captured one cycle after mem_rd_en (still visible, FWFT).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend_i <= 1'b0;
      pend_d <= 1'b0;
      d_wr <= 1'b0;
      owner_d <= 1'b0;
      deliver <= 1'b0;
      addr_i <= '0;
      addr_d <= '0;
      wb_data <= '0;
      wb_mask <= '0;
      i_cmd_full <= 1'b0;
      d_cmd_full <= 1'b0;
      d_wr_full <= 1'b0;
      i_rd_empty <= 1'b1;
      d_rd_empty <= 1'b1;
      i_rd_data <= '0;
      d_rd_data <= '0;
      mem_cmd_en <= 1'b0;
      mem_cmd_instr <= '0;
      mem_cmd_byte_addr <= '0;
      mem_wr_en <= 1'b0;
      mem_wr_data <= '0;
      mem_wr_mask <= '0;
      mem_rd_en <= 1'b0;
    end else begin
      mem_cmd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      i_cmd_full <= pend_i;
      d_cmd_full <= pend_d;
      if (i_cmd_en && !i_cmd_full) begin
        pend_i <= 1'b1;
        addr_i <= i_cmd_byte_addr;
        i_cmd_full <= 1'b1;
      end
      if (d_cmd_en && !d_cmd_full) begin
        pend_d <= 1'b1;
        addr_d <= d_cmd_byte_addr;
        d_wr <= d_cmd_instr == 3'b000;
        d_cmd_full <= 1'b1;
      end
      if (d_wr_en && !d_wr_full) begin
        d_wr_full <= 1'b1;
        wb_data <= d_wr_data;
        wb_mask <= d_wr_mask;
      end
      if (i_rd_en && !i_rd_empty) i_rd_empty <= 1'b1;
      if (d_rd_en && !d_rd_empty) d_rd_empty <= 1'b1;
      if (deliver) begin
        deliver <= 1'b0;
        if (owner_d) begin
          d_rd_data <= mem_rd_data;
          d_rd_empty <= 1'b0;
        end else begin
          i_rd_data <= mem_rd_data;
          i_rd_empty <= 1'b0;
        end
      end
      case (state)
        IDLE:
          if (mem_rd_en) begin
          end else if (!mem_rd_empty) begin
            mem_rd_en <= 1'b1;
          end else if (pick_d && d_wr) begin
            if (!mem_wr_full) begin
              mem_wr_en <= 1'b1;
              mem_wr_data <= wb_data;
              mem_wr_mask <= wb_mask;
              d_wr_full <= 1'b0;
              state <= CMD;
            end
          end else if (el_d || el_i) begin
            if (!mem_cmd_full) begin
              mem_cmd_en <= 1'b1;
              mem_cmd_instr <= 3'b001;
              mem_cmd_byte_addr <= pick_d ? addr_d : addr_i;
              owner_d <= pick_d;
              if (pick_d) pend_d <= 1'b0;
              else pend_i <= 1'b0;
              state <= WAIT;
            end
          end
        CMD:
          if (!mem_cmd_full) begin
            mem_cmd_en <= 1'b1;
            mem_cmd_instr <= 3'b000;
            mem_cmd_byte_addr <= addr_d;
            pend_d <= 1'b0;
            state <= IDLE;
          end
        WAIT:
          if (!mem_rd_empty) begin
            mem_rd_en <= 1'b1;
            deliver <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter; expected commands and return
// words are queued at stimulus time and popped when the DUT produces them.
module tb_mem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_cmd_en = 1'b0, i_cmd_full, i_rd_en = 1'b0, i_rd_empty;
  logic [29:0] i_cmd_byte_addr = '0;
  logic [31:0] i_rd_data;
  logic        d_cmd_en = 1'b0, d_cmd_full, d_wr_en = 1'b0, d_wr_full, d_rd_en = 1'b0, d_rd_empty;
  logic [2:0]  d_cmd_instr = '0;
  logic [29:0] d_cmd_byte_addr = '0;
  logic [31:0] d_wr_data = '0, d_rd_data;
  logic [3:0]  d_wr_mask = '0;
  logic        mem_cmd_en, mem_cmd_full = 1'b0, mem_wr_en, mem_wr_full = 1'b0;
  logic        mem_rd_en, mem_rd_empty = 1'b1;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic [31:0] mem_wr_data, mem_rd_data = '0;
  logic [3:0]  mem_wr_mask;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_en(i_cmd_en), .i_cmd_byte_addr(i_cmd_byte_addr), .i_cmd_full(i_cmd_full),
    .i_rd_en(i_rd_en), .i_rd_data(i_rd_data), .i_rd_empty(i_rd_empty),
    .d_cmd_en(d_cmd_en), .d_cmd_instr(d_cmd_instr), .d_cmd_byte_addr(d_cmd_byte_addr),
    .d_cmd_full(d_cmd_full), .d_wr_en(d_wr_en), .d_wr_data(d_wr_data), .d_wr_mask(d_wr_mask),
    .d_wr_full(d_wr_full), .d_rd_en(d_rd_en), .d_rd_data(d_rd_data), .d_rd_empty(d_rd_empty),
    .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
    .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_cmd_full(mem_cmd_full),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
    .mem_wr_full(mem_wr_full), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_rd_empty(mem_rd_empty)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic [2:0] instr; logic [29:0] addr;} cmd_t;
  typedef struct packed {logic cl; logic [31:0] w;} ret_t;
  cmd_t exp_cmd[$];
  ret_t exp_rd[$];
  int n_assert = 0, n_fail = 0;
  int at, cap, c0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cmd(input string tag, output int t);
    cmd_t e;
    t = -1;
    for (int n = 0; n < 40 && t < 0; n++) if (mem_cmd_en) t = cyc; else tick();
    if (t < 0) check({tag, "_timeout"}, 32'(mem_cmd_en), 1);
    else if (exp_cmd.size() == 0) check({tag, "_unexpected"}, 32'(exp_cmd.size()), 1);
    else begin
      e = exp_cmd.pop_front();
      check({tag, "_instr"}, 32'(mem_cmd_instr), 32'(e.instr));
      check({tag, "_addr"}, 32'(mem_cmd_byte_addr), 32'(e.addr));
      check({tag, "_bl"}, 32'(mem_cmd_bl), 0);
    end
  endtask

  // Present one word in the MCB read FIFO and check it reaches the named client.
  task automatic ret_word(input string tag, input logic cl, input logic [31:0] w, output int t);
    ret_t e;
    exp_rd.push_back({cl, w});
    mem_rd_data = w;
    mem_rd_empty = 1'b0;
    tick();
    check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 1);
    tick();
    mem_rd_empty = 1'b1;
    e = exp_rd.pop_front();
    check({tag, "_rd_empty"}, 32'(e.cl ? d_rd_empty : i_rd_empty), 0);
    check({tag, "_rd_data"}, e.cl ? d_rd_data : i_rd_data, e.w);
    t = cyc;
  endtask

  task automatic req_i(input logic [29:0] a);
    i_cmd_en = 1'b1;
    i_cmd_byte_addr = a;
    exp_cmd.push_back({3'b001, a});
    c0 = cyc;
    tick();
    i_cmd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("rst_i_rd_empty", 32'(i_rd_empty), 1);
    check("rst_d_rd_empty", 32'(d_rd_empty), 1);
    check("rst_i_cmd_full", 32'(i_cmd_full), 0);
    check("rst_d_cmd_full", 32'(d_cmd_full), 0);
    check("rst_d_wr_full", 32'(d_wr_full), 0);
    check("rst_en", 32'({mem_cmd_en, mem_wr_en, mem_rd_en}), 0);
    check("rst_cmd_fields", 32'({mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr}), 0);
    check("rst_rd_data", i_rd_data | d_rd_data | mem_wr_data, 0);
    rst_n = 1'b1;
    tick();

    req_i(30'h40);
    check("i_full_rise", 32'(i_cmd_full), 1);
    wait_cmd("i_read", at);
    check("i_read_lat", 32'(at - c0), 2);
    check("i_full_held", 32'(i_cmd_full), 1);
    tick();
    check("i_full_fall", 32'(i_cmd_full), 0);
    tick();
    tick();
    ret_word("i_read", 1'b0, 32'hDEADBEEF, cap);
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    check("i_pop_empty", 32'(i_rd_empty), 1);
    check("i_pop_hold", i_rd_data, 32'hDEADBEEF);

    i_cmd_en = 1'b1;
    i_cmd_byte_addr = 30'h10;
    d_cmd_en = 1'b1;
    d_cmd_instr = 3'b001;
    d_cmd_byte_addr = 30'h20;
    exp_cmd.push_back({3'b001, 30'h20});
    exp_cmd.push_back({3'b001, 30'h10});
    c0 = cyc;
    tick();
    i_cmd_en = 1'b0;
    d_cmd_en = 1'b0;
    wait_cmd("tie_d", at);
    check("tie_d_lat", 32'(at - c0), 2);
    tick();
    ret_word("tie_d", 1'b1, 32'hA5A50001, cap);
    wait_cmd("tie_i", at);
    check("tie_order", 32'(at > cap), 1);
    tick();
    ret_word("tie_i", 1'b0, 32'h5A5A0002, cap);
    i_rd_en = 1'b1;
    d_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    d_rd_en = 1'b0;
    check("tie_pop", 32'({i_rd_empty, d_rd_empty}), 3);

    d_wr_en = 1'b1;
    d_wr_data = 32'h12345678;
    d_wr_mask = 4'b0011;
    d_cmd_en = 1'b1;
    d_cmd_instr = 3'b000;
    d_cmd_byte_addr = 30'h100;
    mem_wr_full = 1'b1;
    exp_cmd.push_back({3'b000, 30'h100});
    c0 = cyc;
    tick();
    d_wr_en = 1'b0;
    d_cmd_en = 1'b0;
    check("wr_full_rise", 32'({d_wr_full, d_cmd_full}), 3);
    for (int i = 1; i <= 5; i++) begin
      check("wr_blocked", 32'(mem_wr_en), 0);
      if (i == 5) mem_wr_full = 1'b0;
      tick();
    end
    check("wr_en", 32'(mem_wr_en), 1);
    check("wr_lat", 32'(cyc - c0), 6);
    check("wr_data", mem_wr_data, 32'h12345678);
    check("wr_mask", 32'(mem_wr_mask), 32'h3);
    check("wr_buf_clear", 32'(d_wr_full), 0);
    tick();
    wait_cmd("wr_cmd", at);
    check("wr_cmd_lat", 32'(at - c0), 7);
    check("wr_cmd_full_held", 32'(d_cmd_full), 1);
    tick();
    check("wr_cmd_full_fall", 32'(d_cmd_full), 0);

    mem_cmd_full = 1'b1;
    req_i(30'h80);
    for (int i = 1; i <= 4; i++) begin
      check("bp_hold", 32'(mem_cmd_en), 0);
      if (i == 4) mem_cmd_full = 1'b0;
      tick();
    end
    wait_cmd("bp", at);
    check("bp_lat", 32'(at - c0), 5);
    tick();
    ret_word("bp", 1'b0, 32'hCAFE0080, cap);
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;

    req_i(30'h200);
    wait_cmd("blk_i0", at);
    tick();
    ret_word("blk_i0", 1'b0, 32'h11112222, cap);
    i_cmd_en = 1'b1;
    i_cmd_byte_addr = 30'h300;
    tick();
    i_cmd_en = 1'b0;
    d_cmd_en = 1'b1;
    d_cmd_instr = 3'b010;
    d_cmd_byte_addr = 30'h400;
    exp_cmd.push_back({3'b001, 30'h400});
    exp_cmd.push_back({3'b001, 30'h300});
    tick();
    d_cmd_en = 1'b0;
    wait_cmd("blk_d", at);
    tick();
    ret_word("blk_d", 1'b1, 32'h33334444, cap);
    for (int i = 0; i < 5; i++) begin
      check("blk_i_held", 32'(mem_cmd_en), 0);
      tick();
    end
    check("blk_i_data", i_rd_data, 32'h11112222);
    i_rd_en = 1'b1;
    d_rd_en = 1'b1;
    c0 = cyc;
    tick();
    i_rd_en = 1'b0;
    d_rd_en = 1'b0;
    wait_cmd("blk_i1", at);
    check("blk_i1_lat", 32'(at - c0), 2);
    tick();
    ret_word("blk_i1", 1'b0, 32'h55556666, cap);
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;

    req_i(30'h500);
    wait_cmd("rst_wait", at);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_wait_full", 32'(i_cmd_full), 0);
    mem_rd_data = 32'hBAD00BAD;
    mem_rd_empty = 1'b0;
    tick();
    check("drain_en", 32'(mem_rd_en), 1);
    tick();
    mem_rd_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_empty", 32'({i_rd_empty, d_rd_empty}), 3);
      tick();
    end
    check("drain_no_data", i_rd_data | d_rd_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
